sync_fifo_ctrl: RTL and testbench

- Parametrised single-clock FIFO; successor to the team's basic byte FIFO.
- Sits between the RS422 receive/transmit byte engines and the command/science packet logic.
- Adds the following on top of a plain FIFO:
  - selectable show-ahead or registered read mode
  - programmable almost-full and almost-empty thresholds
  - synchronous flush
  - sticky overflow and underflow error flags
- Depth is always a power of two.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr_ctrl.sv | 108 ++++++++++
 rtl/sync_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync FIFO family.
// No logic; sizing functions are elaboration-time only.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PTRWIDTH = 9;

  function automatic int exp2(input int n);
    return 1 << n;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_bits(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef logic [DEF_PTRWIDTH:0] def_ptr_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy/flag engine for sync_fifo_ctrl; optional peak tracker under SYNC_FIFO_PEAK_EN.
// Latency: flags derive from registered pointers, thresholds are compares on usedw.
// Backpressure: writes dropped when full (overflow), reads rejected when empty (underflow).
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int PTRWIDTH  = DEF_PTRWIDTH,
  parameter int AFULL_TH  = 2**PTRWIDTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                valid,
  input  logic                load,
  output logic                wr_en,
  output logic                rd_en,
  output logic [PTRWIDTH-1:0] wr_addr,
  output logic [PTRWIDTH-1:0] rd_addr,
  output logic [PTRWIDTH:0]   usedw,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
`ifdef SYNC_FIFO_PEAK_EN
  ,
  output logic [PTRWIDTH:0]   peak_usedw
`endif
);

  typedef logic [PTRWIDTH:0] ptr_t;

  localparam ptr_t AF_V = ptr_t'(AFULL_TH);
  localparam ptr_t AE_V = ptr_t'(AEMPTY_TH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign wr_addr = wr_ptr_q[PTRWIDTH-1:0];
  assign rd_addr = rd_ptr_q[PTRWIDTH-1:0];
  assign usedw   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_q[PTRWIDTH] != rd_ptr_q[PTRWIDTH]);

  assign almost_full  = (usedw >= AF_V);
  assign almost_empty = (usedw <= AE_V);

  // Flush outranks both requests, so neither side may move a pointer that cycle.
  assign wr_en = valid && !full  && !clr;
  assign rd_en = load  && !empty && !clr;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (valid && full) overflow_d  = 1'b1;
      if (load && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  ptr_t peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clr)                 peak_d = '0;
    else if (usedw > peak_q) peak_d = usedw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_usedw = peak_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with show-ahead/registered read, thresholds, flush, sticky errors; peak via SYNC_FIFO_PEAK_EN.
// Latency: registered mode dout 1 cycle after load; show-ahead mode head word visible combinationally.
// Backpressure: full drops writes (overflow), empty rejects reads (underflow); clr wins over both.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PTRWIDTH  = DEF_PTRWIDTH,
  parameter int AFULL_TH  = 2**PTRWIDTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int SHOWAHEAD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                valid,
  input  logic [WIDTH-1:0]    din,
  input  logic                load,
  output logic [WIDTH-1:0]    dout,
  output logic                fifo_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTRWIDTH:0]   usedw,
  output logic                overflow,
  output logic                underflow
`ifdef SYNC_FIFO_PEAK_EN
  ,
  output logic [PTRWIDTH:0]   peak_usedw
`endif
);

  localparam int DEPTH = exp2(PTRWIDTH);

  logic                wr_en;
  logic                rd_en;
  logic [PTRWIDTH-1:0] wr_addr;
  logic [PTRWIDTH-1:0] rd_addr;

  logic [WIDTH-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .PTRWIDTH  (PTRWIDTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .valid        (valid),
    .load         (load),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .usedw        (usedw),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef SYNC_FIFO_PEAK_EN
    ,
    .peak_usedw   (peak_usedw)
`endif
  );

  // Storage is never reset or flushed; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= din;
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign dout       = mem_q[rd_addr];
    assign fifo_valid = !empty;
  end else begin : g_registered
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             fifo_valid_q, fifo_valid_d;

    always_comb begin
      dout_d       = dout_q;
      fifo_valid_d = 1'b0;
      if (clr) begin
        dout_d = '0;
      end else if (rd_en) begin
        dout_d       = mem_q[rd_addr];
        fifo_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q       <= '0;
        fifo_valid_q <= 1'b0;
      end else begin
        dout_q       <= dout_d;
        fifo_valid_q <= fifo_valid_d;
      end
    end

    assign dout       = dout_q;
    assign fifo_valid = fifo_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: queue reference model, registered instance plus a show-ahead instance.
// Peak tracking is checked when SYNC_FIFO_PEAK_EN is defined.
module tb_sync_fifo_ctrl;

  localparam int W  = 8;
  localparam int PW = 3;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, valid = 1'b0, load = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          fifo_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [PW:0]   usedw;

  logic          sa_clr = 1'b0, sa_valid = 1'b0, sa_load = 1'b0;
  logic [W-1:0]  sa_din = '0;
  logic [W-1:0]  sa_dout;
  logic          sa_fifo_valid, sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;
  logic [PW:0]   sa_usedw;
`ifdef SYNC_FIFO_PEAK_EN
  logic [PW:0]   peak_usedw, sa_peak;
`endif

  int total = 0;
  int bad   = 0;

  int mq[$];
  int exp_q[$];
  bit ovf_m, unf_m;
  int dout_m, peak_m;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.WIDTH(W), .PTRWIDTH(PW), .AFULL_TH(AF), .AEMPTY_TH(AE), .SHOWAHEAD(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .din(din), .load(load),
    .dout(dout), .fifo_valid(fifo_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .usedw(usedw),
    .overflow(overflow), .underflow(underflow)
`ifdef SYNC_FIFO_PEAK_EN
    , .peak_usedw(peak_usedw)
`endif
  );

  sync_fifo_ctrl #(.WIDTH(W), .PTRWIDTH(PW), .AFULL_TH(AF), .AEMPTY_TH(AE), .SHOWAHEAD(1)) dut_sa (
    .clk(clk), .rst_n(rst_n), .clr(sa_clr), .valid(sa_valid), .din(sa_din), .load(sa_load),
    .dout(sa_dout), .fifo_valid(sa_fifo_valid), .full(sa_full), .empty(sa_empty),
    .almost_full(sa_af), .almost_empty(sa_ae), .usedw(sa_usedw),
    .overflow(sa_ovf), .underflow(sa_unf)
`ifdef SYNC_FIFO_PEAK_EN
    , .peak_usedw(sa_peak)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    dout_m = 0;
    peak_m = 0;
  endtask

  task automatic check_status();
    chk("usedw",        usedw,        mq.size());
    chk("full",         full,         mq.size() == D);
    chk("empty",        empty,        mq.size() == 0);
    chk("almost_full",  almost_full,  mq.size() >= AF);
    chk("almost_empty", almost_empty, mq.size() <= AE);
    chk("overflow",     overflow,     ovf_m);
    chk("underflow",    underflow,    unf_m);
`ifdef SYNC_FIFO_PEAK_EN
    chk("peak_usedw",   peak_usedw,   peak_m);
`endif
  endtask

  // One clock of stimulus; the model applies the FIFO rules at the same edge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, input bit c);
    int sz;
    @(negedge clk);
    valid = v; din = d; load = l; clr = c;
    @(posedge clk);
    sz = mq.size();
    if (c) begin
      mq.delete();
      ovf_m = 1'b0; unf_m = 1'b0; dout_m = 0; peak_m = 0;
    end else begin
      if (sz > peak_m) peak_m = sz;
      if (v && sz == D) ovf_m = 1'b1;
      if (l && sz == 0) unf_m = 1'b1;
      if (l && sz > 0) begin
        dout_m = mq.pop_front();
        exp_q.push_back(dout_m);
      end
      if (v && sz < D) mq.push_back(int'(d));
    end
    #1 check_status();
  endtask

  task automatic async_rst();
    @(negedge clk);
    valid = 1'b1; din = 8'h99; load = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check_status();
    chk("rst_fifo_valid", fifo_valid, 0);
    chk("rst_dout",       dout,       0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  // Monitor: every fifo_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", fifo_valid, 0);
        else                   chk("rd_data", dout, exp_q.pop_front());
      end else begin
        if (exp_q.size() != 0) begin
          chk("valid_latency", fifo_valid, 1);
          exp_q.delete();
        end
        chk("dout_hold", dout, dout_m);
      end
    end
  end

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_status();
    chk("reset_dout",       dout,       0);
    chk("reset_fifo_valid", fifo_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    async_rst();
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b1, 8'h78, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int ph, wp, rp;
      ph = (i / 50) % 4;
      wp = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
      rp = (ph == 0) ? 15 : (ph == 1) ? 85 : 50;
      cyc($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp, $urandom_range(59) == 0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    sa_clr = 1'b1;
    @(negedge clk);
    sa_clr = 1'b0; sa_valid = 1'b1; sa_din = 8'h11;
    @(negedge clk);
    sa_din = 8'h22;
    @(negedge clk);
    sa_valid = 1'b0;
    chk("sa_head",        sa_dout,       8'h11);
    chk("sa_valid_level", sa_fifo_valid, 1);
    chk("sa_usedw2",      sa_usedw,      2);
    sa_load = 1'b1;
    @(negedge clk);
    sa_load = 1'b0;
    chk("sa_next",        sa_dout,       8'h22);
    chk("sa_usedw1",      sa_usedw,      1);
`ifdef SYNC_FIFO_PEAK_EN
    chk("sa_peak",        sa_peak,       2);
`endif
    sa_load = 1'b1;
    @(negedge clk);
    sa_load = 1'b0;
    chk("sa_drained",     sa_fifo_valid, 0);
    chk("sa_empty",       sa_empty,      1);
    chk("sa_no_underflow", sa_unf,       0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
